// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: latches decoded instruction state, inserts load-use bubbles,
// and quarantines exception-raising instructions until the exception unit flushes the pipe.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [16:0]       id_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [16:0]       ex_ctrl,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_exc,
  output logic              hz_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              dbg_exc_wait
);

  // Control bit positions within id_ctrl / ex_ctrl
  localparam int C_REGWRITE = 16;
  localparam int C_MEMREAD  = 14;
  localparam int C_MEMWRITE = 13;
  localparam int C_ISLINK   = 8;
  localparam int C_REGDST   = 7;
  localparam int C_EXC_RI   = 3;
  localparam int C_EXC_SYS  = 2;
  localparam int C_COWRITE  = 1;

  localparam logic [16:0] SIDE_FX_MASK = (17'd1 << C_REGWRITE) | (17'd1 << C_MEMREAD) |
                                         (17'd1 << C_MEMWRITE) | (17'd1 << C_COWRITE);

  typedef enum logic [0:0] {RUN = 1'b0, EXC_WAIT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]   ex_pc_q, ex_pc_d;
  logic [DATA_W-1:0]   ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0]   ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0]   ex_imm_q, ex_imm_d;
  logic [16:0]         ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0]    ex_dst_q, ex_dst_d;
  logic                ex_exc_q, ex_exc_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic                id_exc;
  logic                hz;

  assign id_exc = id_ctrl[C_EXC_RI] | id_ctrl[C_EXC_SYS];

  // Load-use: the EX load targets a register the ID instruction reads; $0 is never a hazard.
  assign hz = !flush && (state_q == RUN) && id_valid && ex_valid_q && ex_ctrl_q[C_MEMREAD] &&
              (ex_dst_q != '0) && ((ex_dst_q == id_rs) || (ex_dst_q == id_rt));

  always_comb begin
    state_d      = state_q;
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_dst_d     = ex_dst_q;
    ex_exc_d     = ex_exc_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      ex_exc_d   = 1'b0;
      ex_dst_d   = '0;
      state_d    = RUN;
    end else if (!stall) begin
      if (hz || (state_q == EXC_WAIT) || !id_valid) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
        ex_exc_d   = 1'b0;
        ex_dst_d   = '0;
        if ((hz || (state_q == EXC_WAIT)) && (bubble_cnt_q != '1))
          bubble_cnt_d = bubble_cnt_q + 1'b1;
      end else begin
        ex_valid_d   = 1'b1;
        ex_pc_d      = id_pc;
        ex_rs_data_d = id_rs_data;
        ex_rt_data_d = id_rt_data;
        ex_imm_d     = id_imm;
        ex_exc_d     = id_exc;
        ex_ctrl_d    = id_exc ? (id_ctrl & ~SIDE_FX_MASK) : id_ctrl;
        if (id_ctrl[C_ISLINK])      ex_dst_d = REG_W'(31);
        else if (id_ctrl[C_REGDST]) ex_dst_d = id_rd;
        else                        ex_dst_d = id_rt;
        if (id_exc) state_d = EXC_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_ctrl_q    <= '0;
      ex_dst_q     <= '0;
      ex_exc_q     <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_dst_q     <= ex_dst_d;
      ex_exc_q     <= ex_exc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_dst       = ex_dst_q;
  assign ex_exc       = ex_exc_q;
  assign hz_stall     = hz;
  assign bubble_cnt   = bubble_cnt_q;
  assign dbg_exc_wait = (state_q == EXC_WAIT);

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed and randomized checks of id_ex_pipe against a behavioural model of the
// ID/EX register; a second instance with a 2-bit bubble counter exercises saturation.
module tb_id_ex_pipe;

  localparam logic [16:0] REGWRITE = 17'h10000;
  localparam logic [16:0] MEMTOREG = 17'h08000;
  localparam logic [16:0] MEMREAD  = 17'h04000;
  localparam logic [16:0] MEMWRITE = 17'h02000;
  localparam logic [16:0] ISJUMP   = 17'h00400;
  localparam logic [16:0] ISLINK   = 17'h00100;
  localparam logic [16:0] REGDST   = 17'h00080;
  localparam logic [16:0] ALU_T    = 17'h00010;
  localparam logic [16:0] EXC_RI   = 17'h00008;
  localparam logic [16:0] EXC_SYS  = 17'h00004;
  localparam logic [16:0] COWRITE  = 17'h00002;

  localparam logic [16:0] C_ADDI = REGWRITE | ALU_T;
  localparam logic [16:0] C_LW   = REGWRITE | MEMTOREG | MEMREAD | ALU_T;
  localparam logic [16:0] C_JAL  = REGWRITE | ISJUMP | ISLINK;
  localparam logic [16:0] C_RTYP = REGWRITE | REGDST;
  localparam logic [16:0] C_SYS  = REGWRITE | EXC_SYS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [16:0] id_ctrl;

  logic        ex_valid, ex_exc, hz_stall, dbg_exc_wait;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [16:0] ex_ctrl;
  logic [4:0]  ex_dst;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_exc, s_hz, s_wait;
  logic [31:0] s_pc, s_rs_data, s_rt_data, s_imm;
  logic [16:0] s_ctrl;
  logic [4:0]  s_dst;
  logic [1:0]  s_cnt;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the EX register contents
  bit          m_valid, m_exc, m_wait;
  logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
  logic [16:0] m_ctrl;
  logic [4:0]  m_dst;
  int          m_cnt16, m_cnt2;

  always #5 clk = ~clk;

  id_ex_pipe u_dut (
    .clk(clk), .reset(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_dst(ex_dst), .ex_exc(ex_exc),
    .hz_stall(hz_stall), .bubble_cnt(bubble_cnt), .dbg_exc_wait(dbg_exc_wait)
  );

  id_ex_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data),
    .ex_imm(s_imm), .ex_ctrl(s_ctrl), .ex_dst(s_dst), .ex_exc(s_exc),
    .hz_stall(s_hz), .bubble_cnt(s_cnt), .dbg_exc_wait(s_wait)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_exc = 0; m_wait = 0;
    m_pc = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    m_ctrl = '0; m_dst = '0; m_cnt16 = 0; m_cnt2 = 0;
  endtask

  task automatic check_outputs();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_ctrl", ex_ctrl, m_ctrl);
    chk("ex_dst", ex_dst, m_dst);
    chk("ex_exc", ex_exc, m_exc);
    chk("bubble_cnt", bubble_cnt, m_cnt16);
    chk("sat_bubble_cnt", s_cnt, m_cnt2);
    chk("exc_wait", dbg_exc_wait, m_wait);
    chk("sat_ex_valid", s_valid, m_valid);
    if (m_valid) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs_data", ex_rs_data, m_rs_data);
      chk("ex_rt_data", ex_rt_data, m_rt_data);
      chk("ex_imm", ex_imm, m_imm);
    end
  endtask

  // Drive one cycle of ID inputs, check the combinational hazard, clock, then check EX.
  task automatic step(input bit st, input bit fl, input bit v, input logic [31:0] pc,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [16:0] ctrl);
    bit hz, exc;
    stall = st; flush = fl; id_valid = v; id_pc = pc;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    #1;
    hz = !fl && !m_wait && v && m_valid && ((m_ctrl & MEMREAD) != 0) && m_dst != 0 &&
         (m_dst == rs || m_dst == rt);
    chk("hz_stall", hz_stall, hz);
    chk("sat_hz_stall", s_hz, hz);
    @(posedge clk);
    if (fl) begin
      m_valid = 0; m_ctrl = '0; m_exc = 0; m_dst = '0; m_wait = 0;
    end else if (!st) begin
      if (hz || m_wait || !v) begin
        if (hz || m_wait) begin
          m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
          m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
        m_valid = 0; m_ctrl = '0; m_exc = 0; m_dst = '0;
      end else begin
        exc = ((ctrl & (EXC_RI | EXC_SYS)) != 0);
        m_valid = 1; m_exc = exc;
        m_pc = pc; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
        m_ctrl = exc ? (ctrl & ~(REGWRITE | MEMREAD | MEMWRITE | COWRITE)) : ctrl;
        m_dst = ((ctrl & ISLINK) != 0) ? 5'd31 : ((ctrl & REGDST) != 0) ? rd : rt;
        if (exc) m_wait = 1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_dst", ex_dst, 0);
    chk("rst_ex_exc", ex_exc, 0);
    chk("rst_hz_stall", hz_stall, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_exc_wait", dbg_exc_wait, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    stall = 0; flush = 0; id_valid = 0; id_pc = '0; id_rs_data = '0; id_rt_data = '0;
    id_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0; id_ctrl = '0;
    do_reset();

    // Destination resolution
    step(0, 0, 1, 32'h100, 5'd1, 5'd6, 5'd5, C_JAL);
    chk("jal_dst", ex_dst, 31);
    step(0, 0, 1, 32'h104, 5'd1, 5'd4, 5'd3, C_RTYP);
    chk("rtype_dst", ex_dst, 3);
    step(0, 0, 1, 32'h108, 5'd1, 5'd4, 5'd3, C_ADDI);
    chk("ori_dst", ex_dst, 4);

    // Load-use: one bubble then the dependent instruction enters
    step(0, 0, 1, 32'h10c, 5'd2, 5'd8, 5'd0, C_LW);
    chk("lw_dst", ex_dst, 8);
    step(0, 0, 1, 32'h110, 5'd8, 5'd9, 5'd0, C_ADDI);
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_cnt", bubble_cnt, 1);
    step(0, 0, 1, 32'h110, 5'd8, 5'd9, 5'd0, C_ADDI);
    chk("lu_addi_pc", ex_pc, 32'h110);

    // Reset between edges while streaming ADDI
    step(0, 0, 1, 32'h114, 5'd1, 5'd2, 5'd0, C_ADDI);
    #2;
    do_reset();

    // Exception quarantine
    step(0, 0, 1, 32'h200, 5'd0, 5'd3, 5'd0, C_SYS);
    chk("exc_flag", ex_exc, 1);
    chk("exc_regwrite", ex_ctrl[16], 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h204, 5'd1, 5'd2, 5'd0, C_ADDI);
    chk("exc_bubbles", bubble_cnt, 3);
    step(0, 1, 1, 32'h204, 5'd1, 5'd2, 5'd0, C_ADDI);
    chk("exc_flush_run", dbg_exc_wait, 0);
    step(0, 0, 1, 32'h204, 5'd1, 5'd2, 5'd0, C_ADDI);
    chk("exc_resume", ex_valid, 1);

    // Stall holds, flush beats stall
    step(0, 0, 1, 32'h40, 5'd1, 5'd2, 5'd0, C_ADDI);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 1, 32'h44, 5'd1, 5'd2, 5'd0, C_ADDI);
      chk("stall_hold_pc", ex_pc, 32'h40);
    end
    step(1, 1, 1, 32'h44, 5'd1, 5'd2, 5'd0, C_ADDI);
    chk("stall_flush_valid", ex_valid, 0);

    // Saturation of the 2-bit counter after five load-use bubbles
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 32'h300, 5'd1, 5'd9, 5'd0, C_LW);
      step(0, 0, 1, 32'h304, 5'd9, 5'd2, 5'd0, C_ADDI);
    end
    chk("sat_cnt2", s_cnt, 3);
    chk("sat_cnt16", bubble_cnt, 5);

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [16:0] c;
      c = 17'($urandom);
      if ($urandom_range(0, 5) != 0) c = c & ~(EXC_RI | EXC_SYS);
      if ($urandom_range(0, 2) == 0) c = c | MEMREAD;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
